mem_port_arbiter: RTL

Controller that shares one single-port, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). It arbitrates between the two requesters with round-robin fairness, drives the memory control signals, counts out the memory latency, and returns one response pulse to the winning requester. It sits between the fetch/mem pipeline stages and the unified memory model, replacing separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and the data stage; one response pulse per granted access.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_req_ready_o,
    output logic                  if_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] if_rsp_data_o,
    input  logic                  dm_req_valid_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_req_ready_o,
    output logic                  dm_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] dm_rsp_data_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { PORT_IF, PORT_DM } port_t;

    state_t            state;
    port_t             owner;
    port_t             last_grant;
    logic              owner_we;
    logic              cancel;
    logic [CNT_W-1:0]  cnt;

    logic elig_if;
    logic elig_dm;
    logic grant_if;
    logic grant_dm;

    // Grant is decided in the same cycle the request is seen, so these
    // outputs are combinational from state and inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        elig_if     = (state == IDLE) && if_req_valid_i && !flush_i;
        elig_dm     = (state == IDLE) && dm_req_valid_i;
        grant_dm    = elig_dm && (!elig_if || last_grant == PORT_IF);
        grant_if    = elig_if && !grant_dm;

        if_req_ready_o = grant_if;
        dm_req_ready_o = grant_dm;
        mem_req_o      = grant_if || grant_dm;
        mem_we_o       = grant_dm && dm_we_i;

        if (grant_dm) begin
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
        end else if (grant_if) begin
            mem_addr_o  = if_addr_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            owner          <= PORT_IF;
            owner_we       <= 1'b0;
            last_grant     <= PORT_IF;
            cnt            <= '0;
            cancel         <= 1'b0;
            if_rsp_valid_o <= 1'b0;
            dm_rsp_valid_o <= 1'b0;
            if_rsp_data_o  <= '0;
            dm_rsp_data_o  <= '0;
        end else begin
            if_rsp_valid_o <= 1'b0;
            dm_rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_o) begin
                        owner      <= grant_dm ? PORT_DM : PORT_IF;
                        last_grant <= grant_dm ? PORT_DM : PORT_IF;
                        owner_we   <= mem_we_o;
                        cnt        <= CNT_W'(1);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner == PORT_IF && flush_i)
                        cancel <= 1'b1;
                    if (cnt == CNT_W'(MEM_LATENCY)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        cancel <= 1'b0;
                        if (owner == PORT_DM) begin
                            dm_rsp_valid_o <= 1'b1;
                            dm_rsp_data_o  <= owner_we ? '0 : mem_rdata_i;
                        end else if (!(cancel || flush_i)) begin
                            // A flush in the final cycle still kills the fetch response.
                            if_rsp_valid_o <= 1'b1;
                            if_rsp_data_o  <= mem_rdata_i;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
